// File: rtl/seq_alu.sv
// seq_alu: handshaked, registered ALU. Single-cycle ops finish one cycle after
// accept; signed MUL and DIV iterate one bit per cycle for WIDTH cycles.
// The result and flags are held in DONE until the consumer takes them.
module seq_alu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       command,
  input  logic [WIDTH-1:0] operand_1,
  input  logic [WIDTH-1:0] operand_2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             flag_z,
  output logic             flag_n,
  output logic             flag_c,
  output logic             flag_v,
  output logic             flag_dz,
  output logic             busy
);

  localparam int MSB = WIDTH - 1;
  localparam int SW  = $clog2(WIDTH);
  localparam int CW  = $clog2(WIDTH) + 1;
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
  localparam logic [WIDTH-1:0] MOSTNEG = {1'b1, {(WIDTH-1){1'b0}}};

  // Opcode encodings mirror the shared ALU macro table (ADDALU .. BUFALU)
  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_INC  = 4'd2;
  localparam logic [3:0] OP_DEC  = 4'd3;
  localparam logic [3:0] OP_MUL  = 4'd4;
  localparam logic [3:0] OP_DIV  = 4'd5;
  localparam logic [3:0] OP_SHL  = 4'd6;
  localparam logic [3:0] OP_SHR  = 4'd7;
  localparam logic [3:0] OP_INV  = 4'd8;
  localparam logic [3:0] OP_AND  = 4'd9;
  localparam logic [3:0] OP_OR   = 4'd10;
  localparam logic [3:0] OP_NAND = 4'd11;
  localparam logic [3:0] OP_NOR  = 4'd12;
  localparam logic [3:0] OP_XOR  = 4'd13;
  localparam logic [3:0] OP_XNOR = 4'd14;
  localparam logic [3:0] OP_BUF  = 4'd15;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t              state_reg, state_next;
  logic [CW-1:0]       count_reg;
  logic [2*WIDTH-1:0]  acc_reg;     // MUL: {high partial, multiplier}; DIV: low half = dividend/quotient
  logic [WIDTH-1:0]    dvs_reg;     // magnitude of operand_2 (multiplicand or divisor)
  logic [WIDTH-1:0]    rem_reg;     // DIV partial remainder
  logic                neg_reg;     // operand signs differ: negate final magnitude
  logic                is_mul_reg;
  logic                divov_reg;   // most-negative / -1
  logic [WIDTH-1:0]    result_reg;
  logic                z_reg, n_reg, c_reg, v_reg, dz_reg;

  logic accept, is_iter, last_iter;

  assign in_ready  = (state_reg == IDLE);
  assign out_valid = (state_reg == DONE);
  assign busy      = (state_reg == CALC);
  assign result    = result_reg;
  assign flag_z    = z_reg;
  assign flag_n    = n_reg;
  assign flag_c    = c_reg;
  assign flag_v    = v_reg;
  assign flag_dz   = dz_reg;

  assign accept    = in_valid && in_ready;
  assign is_iter   = (command == OP_MUL) || ((command == OP_DIV) && (operand_2 != '0));
  assign last_iter = (count_reg == CW'(WIDTH - 1));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept) state_next = is_iter ? CALC : DONE;
      CALC:    if (last_iter) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Single-cycle ops, evaluated on the live operands at accept
  logic [WIDTH-1:0] sc_result, other;
  logic [WIDTH:0]   ext;
  logic             sc_c, sc_v, sc_dz, shift_big;
  assign shift_big = |operand_2[WIDTH-1:SW];
  always_comb begin
    sc_result = '0;
    other     = '0;
    ext       = '0;
    sc_c      = 1'b0;
    sc_v      = 1'b0;
    sc_dz     = 1'b0;
    case (command)
      OP_ADD, OP_INC: begin
        other     = (command == OP_INC) ? ONE : operand_2;
        ext       = {1'b0, operand_1} + {1'b0, other};
        sc_result = ext[WIDTH-1:0];
        sc_c      = ext[WIDTH];
        sc_v      = (operand_1[MSB] == other[MSB]) && (sc_result[MSB] != operand_1[MSB]);
      end
      OP_SUB, OP_DEC: begin
        other     = (command == OP_DEC) ? ONE : operand_2;
        ext       = {1'b0, operand_1} - {1'b0, other};
        sc_result = ext[WIDTH-1:0];
        sc_c      = ext[WIDTH];
        sc_v      = (operand_1[MSB] != other[MSB]) && (sc_result[MSB] != operand_1[MSB]);
      end
      OP_DIV: begin
        // only reached with a zero divisor
        sc_result = '1;
        sc_dz     = 1'b1;
      end
      OP_SHL:  sc_result = shift_big ? '0 : (operand_1 << operand_2[SW-1:0]);
      OP_SHR:  sc_result = shift_big ? '0 : (operand_1 >> operand_2[SW-1:0]);
      OP_INV:  sc_result = ~operand_1;
      OP_AND:  sc_result = operand_1 & operand_2;
      OP_OR:   sc_result = operand_1 | operand_2;
      OP_NAND: sc_result = ~(operand_1 & operand_2);
      OP_NOR:  sc_result = ~(operand_1 | operand_2);
      OP_XOR:  sc_result = operand_1 ^ operand_2;
      OP_XNOR: sc_result = ~(operand_1 ^ operand_2);
      OP_BUF:  sc_result = operand_1;
      default: sc_result = '0;
    endcase
  end

  // One iteration step of shift-add multiply / restoring divide, plus final sign fix
  logic [WIDTH:0]     mul_sum, trial;
  logic [2*WIDTH-1:0] mul_next, prod, acc_next;
  logic [WIDTH-1:0]   rem_next, quo_next, quo_signed, fin_result, mag1, mag2;
  logic               ge, mul_v, fin_v;
  assign mag1 = operand_1[MSB] ? -operand_1 : operand_1;
  assign mag2 = operand_2[MSB] ? -operand_2 : operand_2;
  always_comb begin
    mul_sum    = {1'b0, acc_reg[2*WIDTH-1:WIDTH]} + {1'b0, dvs_reg};
    mul_next   = acc_reg[0] ? {mul_sum, acc_reg[WIDTH-1:1]} : {1'b0, acc_reg[2*WIDTH-1:1]};
    trial      = {rem_reg, acc_reg[WIDTH-1]};
    ge         = (trial >= {1'b0, dvs_reg});
    rem_next   = ge ? (trial[WIDTH-1:0] - dvs_reg) : trial[WIDTH-1:0];
    quo_next   = {acc_reg[WIDTH-2:0], ge};
    acc_next   = is_mul_reg ? mul_next : {acc_reg[2*WIDTH-1:WIDTH], quo_next};
    prod       = neg_reg ? -mul_next : mul_next;
    mul_v      = !((&prod[2*WIDTH-1:WIDTH-1]) || (~|prod[2*WIDTH-1:WIDTH-1]));
    quo_signed = neg_reg ? -quo_next : quo_next;
    fin_result = is_mul_reg ? prod[WIDTH-1:0] : quo_signed;
    fin_v      = is_mul_reg ? mul_v : divov_reg;
  end

  // Datapath: latch operands on accept, iterate in CALC, register result and flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg  <= '0;
      acc_reg    <= '0;
      dvs_reg    <= '0;
      rem_reg    <= '0;
      neg_reg    <= 1'b0;
      is_mul_reg <= 1'b0;
      divov_reg  <= 1'b0;
      result_reg <= '0;
      z_reg      <= 1'b0;
      n_reg      <= 1'b0;
      c_reg      <= 1'b0;
      v_reg      <= 1'b0;
      dz_reg     <= 1'b0;
    end else if (accept) begin
      count_reg  <= '0;
      acc_reg    <= {{WIDTH{1'b0}}, mag1};
      dvs_reg    <= mag2;
      rem_reg    <= '0;
      neg_reg    <= operand_1[MSB] ^ operand_2[MSB];
      is_mul_reg <= (command == OP_MUL);
      divov_reg  <= (operand_1 == MOSTNEG) && (&operand_2);
      if (!is_iter) begin
        result_reg <= sc_result;
        z_reg      <= (sc_result == '0);
        n_reg      <= sc_result[MSB];
        c_reg      <= sc_c;
        v_reg      <= sc_v;
        dz_reg     <= sc_dz;
      end
    end else if (state_reg == CALC) begin
      count_reg <= count_reg + 1'b1;
      acc_reg   <= acc_next;
      rem_reg   <= rem_next;
      if (last_iter) begin
        result_reg <= fin_result;
        z_reg      <= (fin_result == '0);
        n_reg      <= fin_result[MSB];
        c_reg      <= 1'b0;
        v_reg      <= fin_v;
        dz_reg     <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: directed checks of seq_alu at WIDTH=32 with hand-computed results.
module tb_seq_alu;

  localparam int W = 32;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_INC  = 4'd2;
  localparam logic [3:0] OP_DEC  = 4'd3;
  localparam logic [3:0] OP_MUL  = 4'd4;
  localparam logic [3:0] OP_DIV  = 4'd5;
  localparam logic [3:0] OP_SHL  = 4'd6;
  localparam logic [3:0] OP_SHR  = 4'd7;
  localparam logic [3:0] OP_NAND = 4'd11;
  localparam logic [3:0] OP_XOR  = 4'd13;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [3:0]   command = '0;
  logic [W-1:0] operand_1 = '0;
  logic [W-1:0] operand_2 = '0;
  logic         in_ready, out_valid, busy;
  logic [W-1:0] result;
  logic         flag_z, flag_n, flag_c, flag_v, flag_dz;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  seq_alu #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .command   (command),
    .operand_1 (operand_1),
    .operand_2 (operand_2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .flag_z    (flag_z),
    .flag_n    (flag_n),
    .flag_c    (flag_c),
    .flag_v    (flag_v),
    .flag_dz   (flag_dz),
    .busy      (busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Present one op, let it be accepted, scramble inputs, wait for out_valid
  task automatic issue(input string tag, input logic [3:0] cmd, input logic [W-1:0] a,
                       input logic [W-1:0] b, input int exp_lat);
    int lat;
    bit busy_ok;
    @(negedge clk);
    command = cmd; operand_1 = a; operand_2 = b; in_valid = 1'b1;
    chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    command = 4'($urandom); operand_1 = $urandom; operand_2 = $urandom;
    lat = 0;
    busy_ok = 1'b1;
    do begin
      @(negedge clk);
      lat++;
      if (!out_valid && (busy !== 1'b1 || in_ready !== 1'b0)) busy_ok = 1'b0;
    end while (!out_valid && lat < 200);
    chk({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    if (exp_lat > 1) chk({tag, "_busy_hold"}, 64'(busy_ok), 64'd1);
  endtask

  // flags packed as {z, n, c, v, dz}
  task automatic expect_out(input string tag, input logic [W-1:0] res, input logic [4:0] flags);
    chk({tag, "_result"}, 64'(result), 64'(res));
    chk({tag, "_flags"}, 64'({flag_z, flag_n, flag_c, flag_v, flag_dz}), 64'(flags));
    $display("op %s result=0x%08h flags(zncvd)=%05b", tag, result,
             {flag_z, flag_n, flag_c, flag_v, flag_dz});
  endtask

  task automatic take(input string tag);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    chk({tag, "_drop_valid"}, 64'(out_valid), 64'd0);
    chk({tag, "_ready_back"}, 64'(in_ready), 64'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int ov_seen;

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_result", 64'(result), 64'd0);
    chk("rst_flags", 64'({flag_z, flag_n, flag_c, flag_v, flag_dz}), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd1);

    issue("add_ovf", OP_ADD, 32'h7FFF_FFFF, 32'h0000_0001, 1);
    expect_out("add_ovf", 32'h8000_0000, 5'b01010);
    take("add_ovf");

    issue("sub_borrow", OP_SUB, 32'h0000_0001, 32'h0000_0002, 1);
    expect_out("sub_borrow", 32'hFFFF_FFFF, 5'b01100);
    take("sub_borrow");

    issue("inc_wrap", OP_INC, 32'hFFFF_FFFF, 32'h1234_5678, 1);
    expect_out("inc_wrap", 32'h0000_0000, 5'b10100);
    take("inc_wrap");

    issue("dec_ovf", OP_DEC, 32'h8000_0000, 32'h0, 1);
    expect_out("dec_ovf", 32'h7FFF_FFFF, 5'b00010);
    take("dec_ovf");

    issue("nand", OP_NAND, 32'hF0F0_F0F0, 32'hFF00_FF00, 1);
    expect_out("nand", 32'h0FFF_0FFF, 5'b00000);
    take("nand");

    issue("xor_zero", OP_XOR, 32'hA5A5_5A5A, 32'hA5A5_5A5A, 1);
    expect_out("xor_zero", 32'h0, 5'b10000);
    take("xor_zero");

    issue("mul_neg", OP_MUL, 32'hFFFF_FFFD, 32'd7, 33);
    expect_out("mul_neg", 32'hFFFF_FFEB, 5'b01000);
    take("mul_neg");

    issue("mul_ovf", OP_MUL, 32'h4000_0000, 32'd4, 33);
    expect_out("mul_ovf", 32'h0, 5'b10010);
    take("mul_ovf");

    issue("div_trunc", OP_DIV, 32'hFFFF_FFF9, 32'd2, 33);
    expect_out("div_trunc", 32'hFFFF_FFFD, 5'b01000);
    take("div_trunc");

    issue("div_zero", OP_DIV, 32'd5, 32'd0, 1);
    expect_out("div_zero", 32'hFFFF_FFFF, 5'b01001);
    take("div_zero");

    issue("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 33);
    expect_out("div_ovf", 32'h8000_0000, 5'b01010);
    take("div_ovf");

    issue("shl_31", OP_SHL, 32'd1, 32'd31, 1);
    expect_out("shl_31", 32'h8000_0000, 5'b01000);
    take("shl_31");

    issue("shl_32", OP_SHL, 32'd1, 32'd32, 1);
    expect_out("shl_32", 32'h0, 5'b10000);
    take("shl_32");

    issue("shr_4", OP_SHR, 32'h8000_0000, 32'd4, 1);
    expect_out("shr_4", 32'h0800_0000, 5'b00000);
    // consumer stalls for 5 cycles; a stray request in the middle must be ignored
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = (i == 2);
      command = OP_ADD; operand_1 = 32'd9; operand_2 = 32'd9;
      chk("hold_result", 64'(result), 64'h0800_0000);
      chk("hold_flags", 64'({flag_z, flag_n, flag_c, flag_v, flag_dz}), 64'd0);
      chk("hold_valid", 64'(out_valid), 64'd1);
      chk("hold_in_ready", 64'(in_ready), 64'd0);
    end
    in_valid = 1'b0;
    take("shr_4");
    ov_seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (out_valid) ov_seen++;
    end
    chk("stray_ignored", 64'(ov_seen), 64'd0);

    // reset in the middle of a multiply
    @(negedge clk);
    command = OP_MUL; operand_1 = 32'd123; operand_2 = 32'd456; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (10) @(negedge clk);
    chk("mid_mul_busy", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_out_valid", 64'(out_valid), 64'd0);
    chk("abort_result", 64'(result), 64'd0);
    chk("abort_flags", 64'({flag_z, flag_n, flag_c, flag_v, flag_dz}), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort_in_ready", 64'(in_ready), 64'd1);
    ov_seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) ov_seen++;
    end
    chk("abort_no_result", 64'(ov_seen), 64'd0);

    issue("add_after_rst", OP_ADD, 32'd2, 32'd3, 1);
    expect_out("add_after_rst", 32'd5, 5'b00000);
    take("add_after_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
